ex_issue_stage: RTL and testbench

ID/EX pipeline register and operand-issue stage of the pipelined RV32I core; sits directly upstream of the ALU. Captures decoded instruction fields each cycle, resolves RAW hazards by forwarding from MEM and WB, and selects PC/immediate. Drives the ALU operand A, operand B and 4-bit op code, plus the EX-stage sideband consumed downstream. Supports pipeline stall and flush.

---
 rtl/ex_pkg.sv | 49 ++++
 rtl/ex_fwd_mux.sv | 43 ++++
 rtl/ex_issue_stage.sv | 95 +++++++++
 tb/tb_ex_issue_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the EX issue stage.
// Optional forwarding is enabled by defining EX_FORWARD_EN.
package ex_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic OPA_RS1 = 1'b0;
    localparam logic OPA_PC  = 1'b1;
    localparam logic OPB_RS2 = 1'b0;
    localparam logic OPB_IMM = 1'b1;

`ifdef EX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    // Forwarding ports stay wired but every hit is masked off.
    localparam bit FWD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [3:0]  alu_op;
        logic        opa_sel;
        logic        opb_sel;
        logic        rd_wren;
    } ex_regs_t;

endpackage

// File: rtl/ex_fwd_mux.sv
// Hit detection and MEM > WB > register priority select for one source operand.
// Hits are only honoured when EX_FORWARD_EN is defined (see ex_pkg::FWD_EN).
module ex_fwd_mux
    import ex_pkg::*;
(
    input  logic [4:0]  src_addr,
    input  logic [31:0] reg_data,
    input  logic        mem_valid,
    input  logic        mem_rd_wren,
    input  logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    input  logic        wb_valid,
    input  logic        wb_rd_wren,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_data,
    output logic [31:0] fwd_data,
    output logic        wb_hit
);
    logic     mem_hit;
    fwd_sel_e sel;

    // x0 is never forwarded; it always reads as the registered zero.
    assign mem_hit = FWD_EN && mem_valid && mem_rd_wren
                     && (mem_rd_addr == src_addr) && (src_addr != 5'd0);
    assign wb_hit  = FWD_EN && wb_valid && wb_rd_wren
                     && (wb_rd_addr == src_addr) && (src_addr != 5'd0);

    always_comb begin
        sel = FWD_NONE;
        if (mem_hit)     sel = FWD_MEM;
        else if (wb_hit) sel = FWD_WB;
    end

    always_comb begin
        fwd_data = reg_data;
        case (sel)
            FWD_MEM: fwd_data = mem_rd_data;
            FWD_WB:  fwd_data = wb_rd_data;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with operand forwarding, stall and flush.
// Define EX_FORWARD_EN to enable MEM/WB forwarding and stall refresh.
module ex_issue_stage
    import ex_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_id_valid,
    input  logic [31:0] i_id_pc,
    input  logic [31:0] i_id_rs1_data,
    input  logic [31:0] i_id_rs2_data,
    input  logic [31:0] i_id_imm,
    input  logic [4:0]  i_id_rs1_addr,
    input  logic [4:0]  i_id_rs2_addr,
    input  logic [4:0]  i_id_rd_addr,
    input  logic [3:0]  i_id_alu_op,
    input  logic        i_id_opa_sel,
    input  logic        i_id_opb_sel,
    input  logic        i_id_rd_wren,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_mem_valid,
    input  logic        i_mem_rd_wren,
    input  logic [4:0]  i_mem_rd_addr,
    input  logic [31:0] i_mem_rd_data,
    input  logic        i_wb_valid,
    input  logic        i_wb_rd_wren,
    input  logic [4:0]  i_wb_rd_addr,
    input  logic [31:0] i_wb_rd_data,
    output logic [31:0] o_operand_a,
    output logic [31:0] o_operand_b,
    output logic [3:0]  o_alu_op,
    output logic        o_ex_valid,
    output logic [31:0] o_ex_pc,
    output logic [4:0]  o_ex_rd_addr,
    output logic        o_ex_rd_wren,
    output logic [31:0] o_ex_rs2_data
);
    ex_regs_t    q;
    logic [31:0] fwd_rs1, fwd_rs2;
    logic        wb_hit_rs1, wb_hit_rs2;

    ex_fwd_mux u_fwd_rs1 (
        .src_addr(q.rs1_addr), .reg_data(q.rs1_data),
        .mem_valid(i_mem_valid), .mem_rd_wren(i_mem_rd_wren),
        .mem_rd_addr(i_mem_rd_addr), .mem_rd_data(i_mem_rd_data),
        .wb_valid(i_wb_valid), .wb_rd_wren(i_wb_rd_wren),
        .wb_rd_addr(i_wb_rd_addr), .wb_rd_data(i_wb_rd_data),
        .fwd_data(fwd_rs1), .wb_hit(wb_hit_rs1)
    );

    ex_fwd_mux u_fwd_rs2 (
        .src_addr(q.rs2_addr), .reg_data(q.rs2_data),
        .mem_valid(i_mem_valid), .mem_rd_wren(i_mem_rd_wren),
        .mem_rd_addr(i_mem_rd_addr), .mem_rd_data(i_mem_rd_data),
        .wb_valid(i_wb_valid), .wb_rd_wren(i_wb_rd_wren),
        .wb_rd_addr(i_wb_rd_addr), .wb_rd_data(i_wb_rd_data),
        .fwd_data(fwd_rs2), .wb_hit(wb_hit_rs2)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            q <= '0;
        end else if (i_flush) begin
            q.valid <= 1'b0;
        end else if (i_stall) begin
            // A producer retiring from WB during the stall would otherwise be lost.
            if (wb_hit_rs1) q.rs1_data <= i_wb_rd_data;
            if (wb_hit_rs2) q.rs2_data <= i_wb_rd_data;
        end else begin
            q.valid    <= i_id_valid;
            q.pc       <= i_id_pc;
            q.rs1_data <= i_id_rs1_data;
            q.rs2_data <= i_id_rs2_data;
            q.imm      <= i_id_imm;
            q.rs1_addr <= i_id_rs1_addr;
            q.rs2_addr <= i_id_rs2_addr;
            q.rd_addr  <= i_id_rd_addr;
            q.alu_op   <= i_id_alu_op;
            q.opa_sel  <= i_id_opa_sel;
            q.opb_sel  <= i_id_opb_sel;
            q.rd_wren  <= i_id_rd_wren;
        end
    end

    assign o_operand_a   = (q.opa_sel == OPA_PC)  ? q.pc  : fwd_rs1;
    assign o_operand_b   = (q.opb_sel == OPB_IMM) ? q.imm : fwd_rs2;
    assign o_ex_rs2_data = fwd_rs2;
    assign o_alu_op      = q.alu_op;
    assign o_ex_valid    = q.valid;
    assign o_ex_pc       = q.pc;
    assign o_ex_rd_addr  = q.rd_addr;
    assign o_ex_rd_wren  = q.rd_wren & q.valid;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Randomized + directed self-checking bench for ex_issue_stage against a slot-level model.
module tb_ex_issue_stage;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_id_valid = 1'b0;
    logic [31:0] i_id_pc = '0, i_id_rs1_data = '0, i_id_rs2_data = '0, i_id_imm = '0;
    logic [4:0]  i_id_rs1_addr = '0, i_id_rs2_addr = '0, i_id_rd_addr = '0;
    logic [3:0]  i_id_alu_op = '0;
    logic        i_id_opa_sel = 1'b0, i_id_opb_sel = 1'b0, i_id_rd_wren = 1'b0;
    logic        i_stall = 1'b0, i_flush = 1'b0;
    logic        i_mem_valid = 1'b0, i_mem_rd_wren = 1'b0;
    logic [4:0]  i_mem_rd_addr = '0;
    logic [31:0] i_mem_rd_data = '0;
    logic        i_wb_valid = 1'b0, i_wb_rd_wren = 1'b0;
    logic [4:0]  i_wb_rd_addr = '0;
    logic [31:0] i_wb_rd_data = '0;
    logic [31:0] o_operand_a, o_operand_b, o_ex_pc, o_ex_rs2_data;
    logic [3:0]  o_alu_op;
    logic        o_ex_valid, o_ex_rd_wren;
    logic [4:0]  o_ex_rd_addr;

    int n_checks = 0;
    int n_errors = 0;

    ex_issue_stage dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
        .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data), .i_id_imm(i_id_imm),
        .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr), .i_id_rd_addr(i_id_rd_addr),
        .i_id_alu_op(i_id_alu_op), .i_id_opa_sel(i_id_opa_sel), .i_id_opb_sel(i_id_opb_sel),
        .i_id_rd_wren(i_id_rd_wren), .i_stall(i_stall), .i_flush(i_flush),
        .i_mem_valid(i_mem_valid), .i_mem_rd_wren(i_mem_rd_wren),
        .i_mem_rd_addr(i_mem_rd_addr), .i_mem_rd_data(i_mem_rd_data),
        .i_wb_valid(i_wb_valid), .i_wb_rd_wren(i_wb_rd_wren),
        .i_wb_rd_addr(i_wb_rd_addr), .i_wb_rd_data(i_wb_rd_data),
        .o_operand_a(o_operand_a), .o_operand_b(o_operand_b), .o_alu_op(o_alu_op),
        .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_rd_addr(o_ex_rd_addr),
        .o_ex_rd_wren(o_ex_rd_wren), .o_ex_rs2_data(o_ex_rs2_data)
    );

    always #5 i_clk = ~i_clk;

    // The instruction currently sitting in the EX slot, as seen architecturally.
    typedef struct {
        bit          valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        bit          opa_pc, opb_imm, wren;
    } slot_t;

    slot_t m, m_nxt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.pc = 0; s.rs1_data = 0; s.rs2_data = 0; s.imm = 0;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.op = 0;
        s.opa_pc = 0; s.opb_imm = 0; s.wren = 0;
        return s;
    endfunction

    // Value a source register has right now: youngest in-flight producer wins, x0 is always the RF value.
    function automatic logic [31:0] current_value(input logic [4:0] a, input logic [31:0] rf_val);
        bit          pv [2];
        logic [4:0]  pa [2];
        logic [31:0] pd [2];
        pv[0] = i_mem_valid && i_mem_rd_wren; pa[0] = i_mem_rd_addr; pd[0] = i_mem_rd_data;
        pv[1] = i_wb_valid  && i_wb_rd_wren;  pa[1] = i_wb_rd_addr;  pd[1] = i_wb_rd_data;
        if (!FWD || a == 0) return rf_val;
        for (int k = 0; k < 2; k++)
            if (pv[k] && pa[k] == a) return pd[k];
        return rf_val;
    endfunction

    function automatic bit wb_writes(input logic [4:0] a);
        return FWD && a != 0 && i_wb_valid && i_wb_rd_wren && i_wb_rd_addr == a;
    endfunction

    task automatic check_outputs();
        chk("ex_valid",  {31'b0, o_ex_valid}, {31'b0, m.valid});
        chk("ex_pc",     o_ex_pc, m.pc);
        chk("alu_op",    {28'b0, o_alu_op}, {28'b0, m.op});
        chk("ex_rd",     {27'b0, o_ex_rd_addr}, {27'b0, m.rd});
        chk("ex_wren",   {31'b0, o_ex_rd_wren}, {31'b0, m.wren && m.valid});
        chk("operand_a", o_operand_a, m.opa_pc ? m.pc : current_value(m.rs1, m.rs1_data));
        chk("operand_b", o_operand_b, m.opb_imm ? m.imm : current_value(m.rs2, m.rs2_data));
        chk("rs2_data",  o_ex_rs2_data, current_value(m.rs2, m.rs2_data));
    endtask

    task automatic model_next();
        m_nxt = m;
        if (i_flush) m_nxt.valid = 0;
        else if (i_stall) begin
            if (wb_writes(m.rs1)) m_nxt.rs1_data = i_wb_rd_data;
            if (wb_writes(m.rs2)) m_nxt.rs2_data = i_wb_rd_data;
        end else begin
            m_nxt.valid = i_id_valid; m_nxt.pc = i_id_pc;
            m_nxt.rs1_data = i_id_rs1_data; m_nxt.rs2_data = i_id_rs2_data; m_nxt.imm = i_id_imm;
            m_nxt.rs1 = i_id_rs1_addr; m_nxt.rs2 = i_id_rs2_addr; m_nxt.rd = i_id_rd_addr;
            m_nxt.op = i_id_alu_op; m_nxt.opa_pc = i_id_opa_sel; m_nxt.opb_imm = i_id_opb_sel;
            m_nxt.wren = i_id_rd_wren;
        end
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic step();
        #1;
        check_outputs();
        model_next();
        @(posedge i_clk);
        m = m_nxt;
        @(negedge i_clk);
    endtask

    task automatic drive_id(input bit v, input logic [31:0] pc, d1, d2, imm,
                            input logic [4:0] a1, a2, rd, input logic [3:0] op,
                            input bit sa, sb, we);
        i_id_valid = v; i_id_pc = pc; i_id_rs1_data = d1; i_id_rs2_data = d2; i_id_imm = imm;
        i_id_rs1_addr = a1; i_id_rs2_addr = a2; i_id_rd_addr = rd; i_id_alu_op = op;
        i_id_opa_sel = sa; i_id_opb_sel = sb; i_id_rd_wren = we;
    endtask

    task automatic drive_fwd(input bit mv, mw, input logic [4:0] ma, input logic [31:0] md,
                             input bit wv, ww, input logic [4:0] wa, input logic [31:0] wd);
        i_mem_valid = mv; i_mem_rd_wren = mw; i_mem_rd_addr = ma; i_mem_rd_data = md;
        i_wb_valid = wv; i_wb_rd_wren = ww; i_wb_rd_addr = wa; i_wb_rd_data = wd;
    endtask

    // Reset asserted at the negedge (mid-cycle), held across one posedge.
    task automatic pulse_reset();
        i_reset = 1'b0;
        #1;
        m = empty_slot();
        chk("rst_valid", {31'b0, o_ex_valid}, 32'd0);
        chk("rst_wren",  {31'b0, o_ex_rd_wren}, 32'd0);
        check_outputs();
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    initial begin
        m = empty_slot();
        drive_fwd(0, 0, 0, 0, 0, 0, 0, 0);
        drive_id(1, 32'hDEAD, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'd5, 0, 0, 1);
        i_stall = 1'b1;
        #3;
        chk("rst_opa",   o_operand_a, 32'd0);
        chk("rst_opb",   o_operand_b, 32'd0);
        chk("rst_pc",    o_ex_pc, 32'd0);
        chk("rst_alu",   {28'b0, o_alu_op}, 32'd0);
        chk("rst_rs2d",  o_ex_rs2_data, 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        i_stall = 1'b0;

        // Plain issue, SUB, no hits
        drive_id(1, 32'h40, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd6, 4'd1, 0, 0, 1);
        step();
        #1;
        chk("plain_opa", o_operand_a, 32'd5);
        chk("plain_opb", o_operand_b, 32'd7);
        chk("plain_alu", {28'b0, o_alu_op}, 32'd1);
        pulse_reset();

        // MEM over WB, then WB alone, then x0
        drive_id(1, 32'h80, 32'h33, 32'h44, 32'h0, 5'd3, 5'd2, 5'd7, 4'd0, 0, 0, 1);
        step();
        i_stall = 1'b1;
        drive_fwd(1, 1, 5'd3, 32'h11, 1, 1, 5'd3, 32'h22);
        #1;
        chk("prio_mem", o_operand_a, FWD ? 32'h11 : 32'h33);
        i_mem_rd_wren = 1'b0;
        #1;
        chk("prio_wb", o_operand_a, FWD ? 32'h22 : 32'h33);
        step();
        i_stall = 1'b0;
        drive_fwd(0, 0, 0, 0, 0, 0, 0, 0);
        drive_id(1, 32'h84, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 4'd0, 0, 0, 1);
        step();
        drive_fwd(1, 1, 5'd0, 32'h11, 1, 1, 5'd0, 32'h22);
        #1;
        chk("prio_x0", o_operand_a, 32'd0);
        step();

        // Stall refresh of held rs2 by a WB retiring mid-stall
        drive_fwd(0, 0, 0, 0, 0, 0, 0, 0);
        drive_id(1, 32'h90, 32'h0, 32'h1, 32'h0, 5'd0, 5'd4, 5'd8, 4'd0, 0, 0, 1);
        step();
        i_stall = 1'b1;
        drive_id(1, 32'h94, 32'h0, 32'h55, 32'h0, 5'd0, 5'd9, 5'd9, 4'd2, 0, 0, 1);
        step();
        drive_fwd(0, 0, 0, 0, 1, 1, 5'd4, 32'h99);
        step();
        drive_fwd(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        #1;
        chk("refresh", o_ex_rs2_data, FWD ? 32'h99 : 32'h1);
        i_stall = 1'b0;
        step();

        // Flush wins over stall
        drive_id(1, 32'hA0, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 4'd0, 0, 0, 1);
        step();
        i_flush = 1'b1; i_stall = 1'b1;
        step();
        #1;
        chk("flush_valid", {31'b0, o_ex_valid}, 32'd0);
        chk("flush_wren",  {31'b0, o_ex_rd_wren}, 32'd0);
        i_flush = 1'b0; i_stall = 1'b0;

        // Operand select, then MEM hit on a rs1 operand
        drive_id(1, 32'h100, 32'h3, 32'h4, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd3, 4'd0, 1, 1, 1);
        step();
        #1;
        chk("sel_opa", o_operand_a, 32'h100);
        chk("sel_opb", o_operand_b, 32'hFFFFFFFC);
        drive_id(1, 32'h104, 32'h77, 32'h4, 32'h0, 5'd5, 5'd2, 5'd3, 4'd0, 0, 0, 1);
        step();
        drive_fwd(1, 1, 5'd5, 32'hAB, 0, 0, 0, 0);
        #1;
        chk("mem_hit_opa", o_operand_a, FWD ? 32'hAB : 32'h77);
        step();

        // Randomized traffic; small register range keeps hazards frequent
        for (int c = 0; c < 3000; c++) begin
            drive_id($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     4'($urandom_range(0, 9)), 1'($urandom), 1'($urandom), 1'($urandom));
            drive_fwd(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                      1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            i_stall = ($urandom_range(0, 3) == 0);
            i_flush = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) pulse_reset();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
